chnl_rx_regfile_loader: RTL and testbench
=========================================

# chnl_rx_regfile_loader

Upstream feeder for the 32 x 32-bit register-file memory on the DE2 Gen1 x1 64-bit RIFFA design. It terminates one RIFFA RX channel and unpacks each 64-bit beat into two 32-bit words. It then issues one register-file write per cycle (wr_addr/wr_en/wr_data) at sequential addresses from a fixed base. Words past the register-file capacity are consumed and flagged, not written.

## Interface
Parameters:
- ADDR_BASE, 0: register-file address of the first word of every transfer.
- MAX_WORDS, 32: words written per transfer; later words are dropped.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- CHNL_RX  in  1  transfer request; held high by host until all data is sent.
- CHNL_RX_ACK  out  1  one-cycle acknowledge of CHNL_RX.
- CHNL_RX_LAST  in  1  last-transfer hint; ignored.
- CHNL_RX_LEN  in  32  transfer length in 32-bit words, valid while CHNL_RX=1.
- CHNL_RX_OFF  in  31  offset; ignored.
- CHNL_RX_DATA  in  64  data beat; word 0 = [31:0], word 1 = [63:32].
- CHNL_RX_DATA_VALID  in  1  beat valid.
- CHNL_RX_DATA_REN  out  1  beat accepted when VALID & REN at a rising edge.
- wr_addr  out  7  register-file write address.
- wr_en  out  1  register-file write strobe.
- wr_data  out  32  register-file write data.
- done  out  1  one-cycle pulse when a transfer completes.
- overflow  out  1  sticky; set if any word was dropped; cleared when the next transfer is acknowledged.

## Operation
- Transfer FSM (IDLE, ACK, RECV, DONE):
  - IDLE: CHNL_RX=1 -> latch len = CHNL_RX_LEN, clear rx_cnt and wr_idx, go to ACK.
  - ACK: CHNL_RX_ACK=1 for exactly this cycle; clear overflow. Go to DONE if len=0, else to RECV.
  - RECV: accept beats. Exit to DONE when rx_cnt >= len and the word buffer is empty.
  - DONE: done=1 on the entry cycle only. Stay until CHNL_RX=0, then go to IDLE. A held-high CHNL_RX never re-triggers a transfer.
- Word buffer: holds 2 x 32 bits plus a count (0..2). The head word is emitted every cycle count>0.
- Beat acceptance: REN = (state==RECV) & (rx_cnt < len) & (count==0 | count==1).
  - With count==1, a simultaneous drain and load is legal.
  - An accepted beat adds min(2, len - rx_cnt) words; rx_cnt advances by the same amount.
  - For odd len, the final beat's word 1 is discarded.
- Write path:
  - wr_data = buffer head; wr_addr = (ADDR_BASE + wr_idx) mod 128.
  - wr_en = (count>0) & (wr_idx < MAX_WORDS).
  - wr_idx increments per emitted word, dropped or not.
  - A word emitted with wr_idx >= MAX_WORDS sets overflow.
- Arithmetic: len, rx_cnt and wr_idx are 32 bits, no wrap within a transfer. Address sum is truncated to 7 bits.
- CHNL_RX falling mid-RECV is ignored; completion is by count only.
- rst at any point: FSM to IDLE, buffer emptied, counters cleared, partial transfer abandoned without done.

## Timing
- Reset values: CHNL_RX_ACK=0, CHNL_RX_DATA_REN=0, wr_en=0, wr_addr=ADDR_BASE[6:0], wr_data=0, done=0, overflow=0.
- CHNL_RX rises in cycle t: ACK high in t+1; REN can be high from t+2.
- Beat accepted at edge k:
  - word 0 is on wr_* in the cycle after edge k and committed at edge k+1.
  - word 1 is committed at edge k+2.
- Sustained rate: one word per cycle, one beat per two cycles. REN is 0 in the cycle after a beat is loaded into an empty buffer.
- done rises in the cycle after the final word's write cycle.
- The register file's read-side indexing is not this block's concern; addresses are absolute.

## Structure
- Package chnl_rx_pkg holds:
  - state enum {S_IDLE, S_ACK, S_RECV, S_DONE};
  - C_BEAT_W=64, C_WORD_W=32, C_ADDR_W=7.
- Sub-module word_unpack64 contains the 2-word buffer, its count, and the load/drain logic.
- The top level contains the FSM, counters, address generation and overflow flag.

## Test plan
- len=4, beats 0x00000002_00000001 and 0x00000004_00000003 -> one ACK pulse; writes (0,1),(1,2),(2,3),(3,4) on consecutive cycles; done once.
- len=3, beats as above -> writes of 1, 2, 3 only; 0x4 never written; exactly 2 beats accepted.
- len=0 -> ACK, then done in the next cycle; no REN, no wr_en.
- len=34, ADDR_BASE=0 -> writes to addresses 0..31; words 33-34 dropped; overflow=1 after done; next ACK clears it.
- VALID toggled 1-0-1 every cycle, len=6 -> the same 6 writes in order; no duplicated or lost words.
- rst asserted mid-RECV after 1 beat, then a new len=2 transfer -> fresh writes at addresses 0,1; no stale word emitted; done only for the new transfer.

Source files
------------

// File: rtl/chnl_rx_pkg.sv
// rtl/chnl_rx_pkg.sv - shared types and widths for the RIFFA RX register-file loader
package chnl_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_RECV,
        S_DONE
    } state_t;

    localparam int C_BEAT_W = 64;
    localparam int C_WORD_W = 32;
    localparam int C_ADDR_W = 7;

endpackage

// File: rtl/chnl_rx_regfile_loader_word_unpack64.sv
// rtl/chnl_rx_regfile_loader_word_unpack64.sv - two-word buffer that splits 64-bit beats into 32-bit words
module word_unpack64
    import chnl_rx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [1:0]          i_nwords,
    input  logic [C_BEAT_W-1:0] i_beat,
    output logic [1:0]          o_count,
    output logic [C_WORD_W-1:0] o_head
);

    logic [C_WORD_W-1:0] r_word0;
    logic [C_WORD_W-1:0] r_word1;
    logic [1:0]          r_count;

    // The head drains every cycle count>0, so a load (only legal at count<=1)
    // always replaces the whole buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word0 <= '0;
            r_word1 <= '0;
            r_count <= 2'd0;
        end else if (i_load) begin
            r_word0 <= i_beat[C_WORD_W-1:0];
            r_word1 <= i_beat[C_BEAT_W-1:C_WORD_W];
            r_count <= i_nwords;
        end else if (r_count != 2'd0) begin
            r_word0 <= r_word1;
            r_count <= r_count - 2'd1;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_word0;

endmodule

// File: rtl/chnl_rx_regfile_loader.sv
// rtl/chnl_rx_regfile_loader.sv - RIFFA RX channel sink writing unpacked words into a 32x32 register file
module chnl_rx_regfile_loader
    import chnl_rx_pkg::*;
#(
    parameter int ADDR_BASE = 0,
    parameter int MAX_WORDS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                CHNL_RX,
    output logic                CHNL_RX_ACK,
    input  logic                CHNL_RX_LAST,
    input  logic [31:0]         CHNL_RX_LEN,
    input  logic [30:0]         CHNL_RX_OFF,
    input  logic [C_BEAT_W-1:0] CHNL_RX_DATA,
    input  logic                CHNL_RX_DATA_VALID,
    output logic                CHNL_RX_DATA_REN,
    output logic [C_ADDR_W-1:0] wr_addr,
    output logic                wr_en,
    output logic [C_WORD_W-1:0] wr_data,
    output logic                done,
    output logic                overflow
);

    localparam logic [C_ADDR_W-1:0] C_BASE = C_ADDR_W'(ADDR_BASE);
    localparam logic [31:0]         C_MAX  = 32'(MAX_WORDS);

    state_t r_state;
    state_t w_next;

    logic [31:0]         r_len;
    logic [31:0]         r_rx_cnt;
    logic [31:0]         r_wr_idx;
    logic                r_overflow;
    logic                r_done;
    logic [1:0]          w_count;
    logic [C_WORD_W-1:0] w_head;
    logic                w_ren;
    logic                w_ack;
    logic                w_accept;
    logic                w_emit;
    logic [1:0]          w_nwords;
    logic [31:0]         w_remain;
    logic                w_unused;

    assign w_unused = ^{CHNL_RX_LAST, CHNL_RX_OFF};

    assign w_remain = r_len - r_rx_cnt;
    assign w_nwords = (w_remain >= 32'd2) ? 2'd2 : 2'd1;
    assign w_accept = w_ren & CHNL_RX_DATA_VALID;
    assign w_emit   = (w_count != 2'd0);

    // RECV exits when the last word is leaving the buffer this cycle, so done
    // lands in the cycle right after the final write.
    always_comb begin
        w_next = r_state;
        w_ren  = 1'b0;
        w_ack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CHNL_RX) w_next = S_ACK;
            end
            S_ACK: begin
                w_ack  = 1'b1;
                w_next = (r_len == 32'd0) ? S_DONE : S_RECV;
            end
            S_RECV: begin
                w_ren = (r_rx_cnt < r_len) && (w_count != 2'd2);
                if ((r_rx_cnt >= r_len) && (w_count <= 2'd1)) w_next = S_DONE;
            end
            S_DONE: begin
                if (!CHNL_RX) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_rx_cnt   <= '0;
            r_wr_idx   <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE) && (r_state != S_DONE);
            if ((r_state == S_IDLE) && CHNL_RX) begin
                r_len    <= CHNL_RX_LEN;
                r_rx_cnt <= '0;
                r_wr_idx <= '0;
            end else begin
                if (w_accept) r_rx_cnt <= r_rx_cnt + {30'd0, w_nwords};
                if (w_emit)   r_wr_idx <= r_wr_idx + 32'd1;
            end
            if (r_state == S_ACK)
                r_overflow <= 1'b0;
            else if (w_emit && (r_wr_idx >= C_MAX))
                r_overflow <= 1'b1;
        end
    end

    word_unpack64 u_unpack (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_nwords (w_nwords),
        .i_beat   (CHNL_RX_DATA),
        .o_count  (w_count),
        .o_head   (w_head)
    );

    assign CHNL_RX_ACK      = w_ack;
    assign CHNL_RX_DATA_REN = w_ren;
    assign wr_addr          = C_BASE + r_wr_idx[C_ADDR_W-1:0];
    assign wr_en            = w_emit && (r_wr_idx < C_MAX);
    assign wr_data          = w_head;
    assign done             = r_done;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_chnl_rx_regfile_loader.sv
// tb/tb_chnl_rx_regfile_loader.sv - directed table-driven bench for chnl_rx_regfile_loader
module tb_chnl_rx_regfile_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        CHNL_RX;
    logic        CHNL_RX_ACK;
    logic        CHNL_RX_LAST;
    logic [31:0] CHNL_RX_LEN;
    logic [30:0] CHNL_RX_OFF;
    logic [63:0] CHNL_RX_DATA;
    logic        CHNL_RX_DATA_VALID;
    logic        CHNL_RX_DATA_REN;
    logic [6:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        done;
    logic        overflow;

    chnl_rx_regfile_loader dut (
        .clk                (clk),
        .rst                (rst),
        .CHNL_RX            (CHNL_RX),
        .CHNL_RX_ACK        (CHNL_RX_ACK),
        .CHNL_RX_LAST       (CHNL_RX_LAST),
        .CHNL_RX_LEN        (CHNL_RX_LEN),
        .CHNL_RX_OFF        (CHNL_RX_OFF),
        .CHNL_RX_DATA       (CHNL_RX_DATA),
        .CHNL_RX_DATA_VALID (CHNL_RX_DATA_VALID),
        .CHNL_RX_DATA_REN   (CHNL_RX_DATA_REN),
        .wr_addr            (wr_addr),
        .wr_en              (wr_en),
        .wr_data            (wr_data),
        .done               (done),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit tog;
        int nwr;
        int beats;
        bit ovf;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int failures = 0;

    logic [6:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int acks, dones, beats, ren_seen, done_cyc, ack_cyc;
    bit ov_done;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_beat(input int off, input int j);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = 32'(off + 2 * j + 1);
        hi = 32'(off + 2 * j + 2);
        return {hi, lo};
    endfunction

    task automatic run_xfer(input int len, input bit tog, input int off, input int abort_at);
        int bi;
        bit acc;
        bit fin;
        bit aborted;
        int post;
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        acks = 0; dones = 0; beats = 0; ren_seen = 0;
        done_cyc = -1; ack_cyc = -1; ov_done = 1'b0;
        fin = 1'b0; aborted = 1'b0; post = 0; bi = 0;
        @(posedge clk); #1;
        CHNL_RX = 1'b1;
        CHNL_RX_LEN = 32'(len);
        CHNL_RX_DATA = mk_beat(off, 0);
        CHNL_RX_DATA_VALID = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (CHNL_RX_ACK) begin acks++; ack_cyc = cyc; end
            if (done) begin dones++; done_cyc = cyc; ov_done = overflow; fin = 1'b1; end
            if (wr_en) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
                wq_cyc.push_back(cyc);
            end
            acc = CHNL_RX_DATA_REN & CHNL_RX_DATA_VALID;
            if (CHNL_RX_DATA_REN) ren_seen++;
            if (acc) beats++;
            @(posedge clk); #1;
            if (acc) bi++;
            CHNL_RX_DATA = mk_beat(off, bi);
            CHNL_RX_DATA_VALID = tog ? ~CHNL_RX_DATA_VALID : 1'b1;
            if (fin) begin
                CHNL_RX = 1'b0;
                post++;
                if (post > 4) break;
            end
            if (abort_at > 0 && beats == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                CHNL_RX = 1'b0;
                CHNL_RX_DATA_VALID = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (!fin && !aborted) check("timeout", 0, 1);
    endtask

    task automatic check_vec(input vec_t v);
        int bad;
        int n;
        run_xfer(v.len, v.tog, 0, 0);
        check("ack_count", acks, 1);
        check("ack_latency", ack_cyc, 1);
        check("done_count", dones, 1);
        check("beats_accepted", beats, v.beats);
        check("write_count", wq_addr.size(), v.nwr);
        bad = 0;
        n = (wq_addr.size() < v.nwr) ? wq_addr.size() : v.nwr;
        for (int k = 0; k < n; k++)
            if (wq_addr[k] != 7'(k) || wq_data[k] != 32'(k + 1)) bad++;
        check("write_addr_data", bad, 0);
        check("overflow_at_done", ov_done, v.ovf);
        check("ren_seen", ren_seen > 0, v.len > 0);
        if (v.len == 0)
            check("done_latency_len0", done_cyc - ack_cyc, 1);
        else if (v.len <= 32 && wq_cyc.size() > 0)
            check("done_after_last_write", done_cyc - wq_cyc[wq_cyc.size() - 1], 1);
        if (!v.tog && wq_cyc.size() > 0)
            check("writes_consecutive", wq_cyc[wq_cyc.size() - 1] - wq_cyc[0], wq_cyc.size() - 1);
    endtask

    initial begin
        vecs[0] = '{len: 4,  tog: 1'b0, nwr: 4,  beats: 2,  ovf: 1'b0};
        vecs[1] = '{len: 3,  tog: 1'b0, nwr: 3,  beats: 2,  ovf: 1'b0};
        vecs[2] = '{len: 0,  tog: 1'b0, nwr: 0,  beats: 0,  ovf: 1'b0};
        vecs[3] = '{len: 34, tog: 1'b0, nwr: 32, beats: 17, ovf: 1'b1};
        vecs[4] = '{len: 4,  tog: 1'b0, nwr: 4,  beats: 2,  ovf: 1'b0};
        vecs[5] = '{len: 6,  tog: 1'b1, nwr: 6,  beats: 3,  ovf: 1'b0};

        rst = 1'b1;
        CHNL_RX = 1'b0;
        CHNL_RX_LAST = 1'b0;
        CHNL_RX_LEN = '0;
        CHNL_RX_OFF = '0;
        CHNL_RX_DATA = '0;
        CHNL_RX_DATA_VALID = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", CHNL_RX_ACK, 0);
        check("rst_ren", CHNL_RX_DATA_REN, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) check_vec(vecs[i]);

        run_xfer(4, 1'b0, 'h100, 1);
        check("abort_done_count", dones, 0);
        @(negedge clk);
        check("abort_wr_en_cleared", wr_en, 0);
        check("abort_ren_cleared", CHNL_RX_DATA_REN, 0);
        check_vec('{len: 2, tog: 1'b0, nwr: 2, beats: 1, ovf: 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
